// File: rtl/icache_fetch.sv
// Direct-mapped, one-word-per-line instruction cache refilled byte-serially from mem_ctrl.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_fetch #(
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_pc,
    output logic              req_ready,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_byte_vld,
    input  logic [7:0]        mem_byte
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int unsigned LINES = 1 << IDX_W;
    localparam int unsigned TAG_W = 16 - IDX_W;

    typedef enum logic [1:0] {StIdle, StRefill, StResp} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [2:0]          issue_q, issue_d;
    logic [2:0]          recv_q, recv_d;
    logic [31:0]         buf_q, buf_d;
    logic                squash_q, squash_d;
    logic                inst_valid_q, inst_valid_d;
    logic [31:0]         inst_q, inst_d;
    logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
    logic [LINES-1:0]    valid_q;
    logic [31:0]         data_q [LINES];
    logic [TAG_W-1:0]    tag_q [LINES];

    logic [IDX_W-1:0]    req_idx, fill_idx;
    logic [TAG_W-1:0]    req_tag, fill_tag;
    logic                hit, accept, fill_we;
    logic [31:0]         fill_data;

    assign req_idx  = req_pc[IDX_W+1:2];
    assign req_tag  = req_pc[17:IDX_W+2];
    assign fill_idx = pc_q[IDX_W+1:2];
    assign fill_tag = pc_q[17:IDX_W+2];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign accept   = (state_q == StIdle) && req_valid && !clear;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        issue_d      = issue_q;
        recv_d       = recv_q;
        buf_d        = buf_q;
        squash_d     = squash_q;
        inst_valid_d = 1'b0;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        fill_we      = 1'b0;
        fill_data    = buf_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (hit) begin
                        inst_valid_d = 1'b1;
                        inst_d       = data_q[req_idx];
                        inst_pc_d    = req_pc;
                    end else begin
                        pc_d     = req_pc;
                        issue_d  = 3'd0;
                        recv_d   = 3'd0;
                        squash_d = 1'b0;
                        state_d  = StRefill;
                    end
                end
            end
            StRefill: begin
                if (clear) squash_d = 1'b1;
                if (mem_gnt && !issue_q[2]) issue_d = issue_q + 3'd1;
                if (mem_byte_vld) begin
                    buf_d[{recv_q[1:0], 3'b000} +: 8] = mem_byte;
                    recv_d = recv_q + 3'd1;
                    if (recv_q == 3'd3) begin
                        // Line is filled even when squashed: instruction memory is static.
                        fill_we   = 1'b1;
                        fill_data = buf_d;
                        state_d   = StResp;
                        if (!(squash_q || clear)) begin
                            inst_valid_d = 1'b1;
                            inst_d       = buf_d;
                            inst_pc_d    = pc_q;
                        end
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= StIdle;
            pc_q         <= '0;
            issue_q      <= 3'd0;
            recv_q       <= 3'd0;
            buf_q        <= 32'd0;
            squash_q     <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'd0;
            inst_pc_q    <= '0;
            valid_q      <= '0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            issue_q      <= issue_d;
            recv_q       <= recv_d;
            buf_q        <= buf_d;
            squash_q     <= squash_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            if (fill_we) valid_q[fill_idx] <= 1'b1;
        end
    end

    // Data and tag arrays need no reset; the valid bits gate every lookup.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && fill_we) begin
            data_q[fill_idx] <= fill_data;
            tag_q[fill_idx]  <= fill_tag;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign inst_valid = inst_valid_q && !clear;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign mem_req    = (state_q == StRefill) && !issue_q[2];
    assign mem_addr   = mem_req ? {pc_q[ADDR_W-1:2], issue_q[1:0]} : '0;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else if (rdy_in) begin
            if (accept && hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (accept && !hit) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Directed and randomized bench for icache_fetch against a line-occupancy reference model
// and a byte-serial memory responder.
module tb_icache_fetch;
    localparam int IDX_W  = 6;
    localparam int ADDR_W = 32;

    logic              clk_in = 1'b0;
    logic              rst_in, rdy_in, clear, req_valid;
    logic [ADDR_W-1:0] req_pc;
    logic              req_ready, inst_valid, mem_req;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] inst_pc, mem_addr;
    logic              mem_gnt, mem_byte_vld;
    logic [7:0]        mem_byte;
`ifdef ICACHE_STATS_EN
    logic [31:0]       hit_cnt, miss_cnt;
`endif

    always #5 clk_in = ~clk_in;

    icache_fetch #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .clear        (clear),
        .req_valid    (req_valid),
        .req_pc       (req_pc),
        .req_ready    (req_ready),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_byte_vld (mem_byte_vld),
        .mem_byte     (mem_byte)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // gnt_mode: 0 = held high, 1 = random, 2 = toggling
    int          gnt_mode = 0;
    logic        o_ready, o_ivld, o_mreq;
    logic [31:0] o_inst, o_ipc, o_maddr;
    logic [31:0] granted[$];
    int          mreq_cycles;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;

    // Reference model: which word address (pc[17:2]) each line currently holds.
    bit          mv [64];
    logic [15:0] mline [64];
    int          exp_hits = 0;
    int          exp_misses = 0;

    function automatic logic [7:0] memf(input logic [31:0] a);
        if (a[17:2] == 16'd0) return (a[1:0] == 2'd0) ? 8'h13 : 8'h00;
        return (a[7:0] * 8'd37) ^ a[15:8] ^ {6'd0, a[17:16]} ^ 8'h5a;
    endfunction

    function automatic logic [31:0] memword(input logic [31:0] pc);
        logic [31:0] b;
        b = {pc[31:2], 2'b00};
        return {memf(b + 3), memf(b + 2), memf(b + 1), memf(b)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: snapshot outputs at negedge, then act as mem_ctrl just after the edge.
    task automatic cyc();
        logic g, live;
        logic [31:0] ga;
        @(negedge clk_in);
        o_ready = req_ready; o_ivld = inst_valid; o_inst = inst; o_ipc = inst_pc;
        o_mreq = mem_req; o_maddr = mem_addr;
        if (mem_req) mreq_cycles++;
        if (prev_hold && mem_req) check("addr_hold", mem_addr, prev_addr);
        prev_hold = mem_req && !(rdy_in && mem_gnt) && !rst_in;
        prev_addr = mem_addr;
        live = rdy_in && !rst_in;
        g = live && mem_req && mem_gnt;
        ga = mem_addr;
        if (g) granted.push_back(ga);
        @(posedge clk_in);
        #1;
        if (live || rst_in) begin
            mem_byte_vld = g;
            mem_byte = g ? memf(ga) : 8'h00;
            case (gnt_mode)
                0: mem_gnt = 1'b1;
                1: mem_gnt = 1'($urandom);
                default: mem_gnt = ~mem_gnt;
            endcase
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        repeat (2) cyc();
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        rst_in = 1'b0;
    endtask

    // Issue one fetch and wait for its instruction; exp_lat < 0 skips the miss latency check.
    task automatic fetch(input logic [31:0] pc, input int stall_at, input int exp_lat);
        bit          exp_hit;
        int          idx, lat;
        logic [31:0] held;
        idx = int'(pc[IDX_W+1:2]);
        exp_hit = mv[idx] && (mline[idx] == pc[17:2]);
        granted.delete();
        mreq_cycles = 0;
        req_valid = 1'b1; req_pc = pc;
        cyc();
        check("accept_ready", {31'd0, o_ready}, 32'd1);
        req_valid = 1'b0;
        lat = 0;
        do begin
            if (stall_at != 0 && lat == stall_at) begin
                rdy_in = 1'b0;
                cyc(); lat++;
                held = o_maddr;
                repeat (2) begin
                    cyc(); lat++;
                    check("stall_addr", o_maddr, held);
                end
                rdy_in = 1'b1;
            end
            cyc(); lat++;
        end while (!o_ivld && lat < 200);
        check("inst_valid", {31'd0, o_ivld}, 32'd1);
        check("inst", o_inst, memword(pc));
        check("inst_pc", o_ipc, pc);
        if (exp_hit) begin
            exp_hits++;
            check("hit_latency", lat, 1);
            check("hit_no_mem_req", mreq_cycles, 0);
        end else begin
            exp_misses++;
            if (exp_lat >= 0) check("miss_latency", lat, exp_lat);
            check("grant_count", granted.size(), 4);
            for (int k = 0; k < 4 && k < granted.size(); k++)
                check("grant_addr", granted[k], {pc[31:2], 2'(k)});
            mv[idx] = 1'b1;
            mline[idx] = pc[17:2];
        end
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; req_valid = 1'b0; req_pc = '0;
        mem_gnt = 1'b1; mem_byte_vld = 1'b0; mem_byte = 8'h00;

        do_reset();
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_ivld", {31'd0, o_ivld}, 32'd0);
        check("rst_inst", o_inst, 32'd0);
        check("rst_inst_pc", o_ipc, 32'd0);
        check("rst_mem_req", {31'd0, o_mreq}, 32'd0);
        check("rst_mem_addr", o_maddr, 32'd0);

        // First fill and a repeat hit
        fetch(32'h0000_0000, 0, 6);
        check("first_inst", o_inst, 32'h0000_0013);
        fetch(32'h0000_0000, 0, 6);

        // Aliasing on index 1
        fetch(32'h0000_0004, 0, 6);
        fetch(32'h0000_0104, 0, 6);
        fetch(32'h0000_0004, 0, 6);

        // Flush at t3 of a refill of 0x20
        req_valid = 1'b1; req_pc = 32'h20;
        cyc();
        req_valid = 1'b0;
        cyc(); cyc();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        for (int t = 4; t <= 6; t++) begin
            cyc();
            check("squash_ivld", {31'd0, o_ivld}, 32'd0);
            check("squash_busy", {31'd0, o_ready}, 32'd0);
        end
        cyc();
        check("squash_ready_t7", {31'd0, o_ready}, 32'd1);
        check("squash_ivld_t7", {31'd0, o_ivld}, 32'd0);
        mv[8] = 1'b1; mline[8] = 16'h0008; exp_misses++;
        fetch(32'h0000_0020, 0, 6);

        // Request dropped by a same-cycle clear
        mreq_cycles = 0;
        req_valid = 1'b1; req_pc = 32'h0000_0400; clear = 1'b1;
        cyc();
        req_valid = 1'b0; clear = 1'b0;
        cyc();
        check("drop_ivld", {31'd0, o_ivld}, 32'd0);
        check("drop_ready", {31'd0, o_ready}, 32'd1);
        check("drop_no_mem_req", mreq_cycles, 0);

        // Hit response suppressed by clear in the response cycle
        req_valid = 1'b1; req_pc = 32'h0000_0020;
        cyc();
        req_valid = 1'b0; clear = 1'b1;
        cyc();
        clear = 1'b0;
        check("clear_hit_ivld", {31'd0, o_ivld}, 32'd0);
        exp_hits++;

        // rdy_in low for 3 cycles mid-refill
        fetch(32'h0000_0300, 2, 9);

        // Toggling grant
        gnt_mode = 2;
        fetch(32'h0000_0a08, 0, -1);
        fetch(32'hfffc_0a0c, 0, -1);

        // Randomized traffic over a few aliasing tags and random upper bits
        gnt_mode = 1;
        for (int n = 0; n < 150; n++) begin
            logic [31:0] pc;
            pc = {14'($urandom), 8'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  2'($urandom)};
            fetch(pc, 0, -1);
        end
        gnt_mode = 0;

`ifdef ICACHE_STATS_EN
        check("hit_cnt", hit_cnt, exp_hits);
        check("miss_cnt", miss_cnt, exp_misses);
        do_reset();
        check("hit_cnt_rst", hit_cnt, 32'd0);
        check("miss_cnt_rst", miss_cnt, 32'd0);
        fetch(32'h0000_0010, 0, 6);
        fetch(32'h0000_0014, 0, 6);
        fetch(32'h0000_0010, 0, 6);
        fetch(32'h0000_0010, 0, 6);
        fetch(32'h0000_0014, 0, 6);
        check("hit_cnt_3", hit_cnt, 32'd3);
        check("miss_cnt_2", miss_cnt, 32'd2);
`endif

        // Reset invalidates all lines
        do_reset();
        fetch(32'h0000_0000, 0, 6);
        check("post_reset_refill", granted.size(), 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
